// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with a drain FSM that feeds the uart TX send/busy interface
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_BITS-1:0]   tx_data,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_send_q, tx_send_d;
  logic                 push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = count_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;

  // A flushing cycle never stores the byte offered alongside it.
  assign push = in_valid && !full && !flush;
  assign pop  = (state_q == S_IDLE) && !empty;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    tx_send_d = tx_send_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d = mem[rd_ptr_q];
          tx_send_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + PW'(1);
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        tx_send_d = 1'b0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      default: begin
        if (!tx_busy) state_d = S_IDLE;
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush empties the queue but lets an in-flight pop and character complete.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo with a behavioural uart busy model
module tb_uart_tx_fifo;

  localparam int BUSY_LEN = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy = 1'b0;
  logic [4:0] count;
  logic       empty;
  logic       full;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic stall = 1'b0;
  logic mute  = 1'b0;
  int   bcnt  = 0;
  logic prev_busy = 1'b0;

  int         send_cyc[$];
  logic [7:0] send_dat[$];
  int         fall_cyc[$];

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // uart stand-in: busy the cycle after it samples tx_send, for BUSY_LEN cycles
  always @(posedge clock) begin
    if (mute) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_send) begin
      tx_busy <= 1'b1;
      bcnt    <= BUSY_LEN - 1;
    end else if (bcnt != 0) begin
      tx_busy <= 1'b1;
      bcnt    <= bcnt - 1;
    end else begin
      tx_busy <= stall;
    end
  end

  always @(negedge clock) begin
    if (tx_send) begin
      send_cyc.push_back(cyc);
      send_dat.push_back(tx_data);
    end
    if (prev_busy && !tx_busy) fall_cyc.push_back(cyc);
    prev_busy <= tx_busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    send_cyc.delete();
    send_dat.delete();
    fall_cyc.delete();
  endtask

  task automatic wait_sends(input int n, input int limit, input string tag);
    int c = 0;
    while (send_dat.size() < n && c < limit) begin
      tick();
      c++;
    end
    check_eq(tag, send_dat.size(), n);
  endtask

  // Park the drain FSM in WAIT_DONE by issuing one byte and then holding busy high.
  task automatic park_busy(input logic [7:0] b);
    push_byte(b);
    repeat (5) tick();
    stall = 1'b1;
    repeat (25) tick();
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_tx_send", tx_send, 0);
    check_eq("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    tick();

    // Single byte latency: accepted in cycle k, tx_send in k+2 only.
    push_byte(8'h55);
    check_eq("t1_count_k1", count, 1);
    check_eq("t1_send_k1", tx_send, 0);
    tick();
    check_eq("t1_send_k2", tx_send, 1);
    check_eq("t1_data_k2", tx_data, 8'h55);
    check_eq("t1_count_k2", count, 0);
    tick();
    check_eq("t1_send_k3", tx_send, 0);
    repeat (3) tick();
    stall = 1'b1;
    repeat (25) tick();

    // Fill to full while the uart is held busy; writes wrap the pointer past 15.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
    end
    in_data = 8'hAA;
    check_eq("t2_full", full, 1);
    check_eq("t2_in_ready", in_ready, 0);
    check_eq("t2_count", count, 16);
    repeat (2) tick();
    in_valid = 1'b0;
    check_eq("t2_count_no_overflow", count, 16);

    // Drain from full: order, in_ready recovery, and 2-cycle gap after each busy fall.
    clear_logs();
    stall = 1'b0;
    wait_sends(1, 10, "t3_first_send");
    check_eq("t3_count_after_pop", count, 15);
    check_eq("t3_in_ready_after_pop", in_ready, 1);
    wait_sends(16, 16 * 30, "t3_all_sends");
    for (int i = 0; i < 16; i++) begin
      check_eq("t3_data", send_dat[i], i + 1);
      check_eq("t3_gap", send_cyc[i] - fall_cyc[i], 2);
    end
    repeat (30) tick();
    check_eq("t3_empty", empty, 1);

    // Simultaneous push and pop at count=3.
    park_busy(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    check_eq("t4_count_pre", count, 3);
    clear_logs();
    stall = 1'b0;
    repeat (2) tick();
    in_valid = 1'b1;
    in_data  = 8'hA4;
    tick();
    in_valid = 1'b0;
    check_eq("t4_count_pushpop", count, 3);
    check_eq("t4_send", tx_send, 1);
    check_eq("t4_data", tx_data, 8'hA1);
    wait_sends(4, 4 * 30, "t4_sends");
    for (int i = 0; i < 4; i++) check_eq("t4_order", send_dat[i], 8'hA1 + 8'(i));
    repeat (30) tick();

    // Flush in WAIT_DONE with 5 queued and a concurrent push.
    park_busy(8'hC0);
    for (int i = 1; i <= 5; i++) push_byte(8'hC0 + 8'(i));
    check_eq("t5_count_pre", count, 5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("t5_count_flush", count, 0);
    check_eq("t5_empty_flush", empty, 1);
    clear_logs();
    stall = 1'b0;
    repeat (40) tick();
    check_eq("t5_no_send", send_dat.size(), 0);
    check_eq("t5_busy_done", fall_cyc.size(), 1);
    check_eq("t5_empty_end", empty, 1);

    // Reset while stuck in WAIT_BUSY with 4 queued.
    mute = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hD0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check_eq("t6_count_pre", count, 4);
    check_eq("t6_tx_data_pre", tx_data, 8'hD0);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_count", count, 0);
    check_eq("t6_rst_empty", empty, 1);
    check_eq("t6_rst_send", tx_send, 0);
    check_eq("t6_rst_data", tx_data, 0);
    check_eq("t6_rst_in_ready", in_ready, 1);
    repeat (2) tick();
    reset = 1'b0;
    mute  = 1'b0;
    tick();
    push_byte(8'h3C);
    check_eq("t6_count_k1", count, 1);
    tick();
    check_eq("t6_send_k2", tx_send, 1);
    check_eq("t6_data_k2", tx_data, 8'h3C);
    tick();
    check_eq("t6_send_k3", tx_send, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
